// File: rtl/cpu_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: PCSrc encodings,
// fetch FSM states, instruction field bounds and a branch-offset helper.
// Optional feature macro: FETCH_TIMEOUT_EN (adds the HALT state).
package cpu_fetch_pkg;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b11;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;
  localparam int JIDX_MSB  = 25;
  localparam int JIDX_LSB  = 0;

`ifdef FETCH_TIMEOUT_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_HOLD = 2'b10,
    ST_HALT = 2'b11
  } fetch_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_HOLD = 2'b10
  } fetch_state_e;
`endif

  // Sign-extended 16-bit branch immediate, scaled to a byte offset.
  function automatic logic [31:0] br_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential, conditional branch or jump.
// The reserved PCSrc encoding falls back to sequential.
import cpu_fetch_pkg::*;

module next_pc_calc (
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic [1:0]  PCSrc,
  input  logic        Zero,
  output logic [31:0] next_pc
);

  logic [31:0] seq_pc_s;
  logic        unused_op_s;

  assign seq_pc_s    = pc + 32'd4;
  // Opcode bits play no part in target arithmetic.
  assign unused_op_s = ^instr[OP_MSB:OP_LSB];

  // Select the next PC from the decoded PCSrc.
  always_comb begin
    next_pc = seq_pc_s;
    case (PCSrc)
      PCSRC_SEQ: next_pc = seq_pc_s;
      PCSRC_BR: begin
        if (Zero) begin
          next_pc = seq_pc_s + br_offset(instr[IMM_MSB:IMM_LSB]);
        end else begin
          next_pc = seq_pc_s;
        end
      end
      PCSRC_JMP: next_pc = {seq_pc_s[31:28], instr[JIDX_MSB:JIDX_LSB], 2'b00};
      default:   next_pc = seq_pc_s;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns PC and IR, fetches over a req/ack handshake
// and advances the PC when the control unit strobes PCEn.
// Optional feature macro: FETCH_TIMEOUT_EN (ack-wait timeout, sticky
// fetch_err and a HALT state left only through reset).
import cpu_fetch_pkg::*;

module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        PCEn,
  input  logic [1:0]  PCSrc,
  input  logic        Zero,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_err
);

  fetch_state_e state_r, state_next_s;
  logic [31:0]  pc_r, instr_r, next_pc_s;
  logic         instr_valid_r;
  logic         pc_load_s, ir_load_s, err_set_s;

  next_pc_calc u_next_pc (
    .pc      (pc_r),
    .instr   (instr_r),
    .PCSrc   (PCSrc),
    .Zero    (Zero),
    .next_pc (next_pc_s)
  );

`ifdef FETCH_TIMEOUT_EN
  logic [31:0] wait_cnt_r;
  logic        fetch_err_r;
  logic        timeout_s;

  assign timeout_s = (wait_cnt_r == 32'(TIMEOUT_CYCLES - 1));
`else
  logic unused_cfg_s;
  assign unused_cfg_s = (TIMEOUT_CYCLES == 0);
`endif

  // Next-state and register-enable decode for the fetch FSM.
  always_comb begin
    state_next_s = state_r;
    pc_load_s    = 1'b0;
    ir_load_s    = 1'b0;
    err_set_s    = 1'b0;
    case (state_r)
      ST_IDLE: state_next_s = ST_REQ;
      ST_REQ: begin
        if (imem_ack) begin
          ir_load_s    = 1'b1;
          state_next_s = ST_HOLD;
`ifdef FETCH_TIMEOUT_EN
        end else if (timeout_s) begin
          err_set_s    = 1'b1;
          state_next_s = ST_HALT;
`endif
        end else begin
          state_next_s = ST_REQ;
        end
      end
      ST_HOLD: begin
        if (PCEn) begin
          pc_load_s    = 1'b1;
          state_next_s = ST_REQ;
        end else begin
          state_next_s = ST_HOLD;
        end
      end
`ifdef FETCH_TIMEOUT_EN
      ST_HALT: state_next_s = ST_HALT;
`endif
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) state_r <= ST_IDLE;
    else        state_r <= state_next_s;
  end

  // Program counter; only moves on a PCEn strobe accepted in HOLD.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset)         pc_r <= RESET_PC;
    else if (pc_load_s) pc_r <= next_pc_s;
    else                pc_r <= pc_r;
  end

  // Instruction register and its valid flag.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      instr_r       <= 32'h0000_0000;
      instr_valid_r <= 1'b0;
    end else if (ir_load_s) begin
      instr_r       <= imem_rdata;
      instr_valid_r <= 1'b1;
    end else if (pc_load_s) begin
      instr_r       <= instr_r;
      instr_valid_r <= 1'b0;
    end else begin
      instr_r       <= instr_r;
      instr_valid_r <= instr_valid_r;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  // Ack-wait counter: cleared outside REQ, counts REQ cycles without ack.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset)                            wait_cnt_r <= 32'd0;
    else if (state_r != ST_REQ)            wait_cnt_r <= 32'd0;
    else if (!imem_ack)                    wait_cnt_r <= wait_cnt_r + 32'd1;
    else                                   wait_cnt_r <= wait_cnt_r;
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset)         fetch_err_r <= 1'b0;
    else if (err_set_s) fetch_err_r <= 1'b1;
    else                fetch_err_r <= fetch_err_r;
  end

  assign fetch_err = fetch_err_r;
`else
  assign fetch_err = 1'b0;
`endif

  // Request decoded from state so reset drops it without a clock edge.
  assign imem_req    = (state_r == ST_REQ);
  assign imem_addr   = pc_r;
  assign pc          = pc_r;
  assign pc_plus4    = pc_r + 32'd4;
  assign instr       = instr_r;
  assign instr_valid = instr_valid_r;
  assign op          = instr_r[OP_MSB:OP_LSB];
  assign funct       = instr_r[FUNCT_MSB:FUNCT_LSB];

  // Tie-off to keep err_set_s referenced in the default build.
`ifndef FETCH_TIMEOUT_EN
  logic unused_err_s;
  assign unused_err_s = err_set_s;
`endif

endmodule
